// File: rtl/hazard_stall_ctrl.sv
// Purpose : stall/flush decisions for the 5-stage pipeline (load-use bubble, data-memory freeze, taken-branch IF/ID flush).
// Latency : outputs are combinational from the FSM state and the current inputs (zero cycles); state advances on clk_i.
// Backpr. : mem_stall_i freezes the whole pipe and takes priority; load-use stalls hold PC and IF/ID and bubble ID/EX.
//
// Ports
//   clk_i, rst_i            clock, synchronous active-high reset
//   IF_ID_RSaddr_i/RTaddr_i source registers of the instruction in ID
//   ID_EX_RTaddr_i          destination of the instruction in EX
//   ID_EX_MemRead_i         instruction in EX is a load
//   mem_stall_i             data memory not ready this cycle
//   branch_taken_i          branch in ID resolved taken
//   PCWrite_o               PC load enable
//   IF_ID_Write_o           IF/ID load enable
//   IF_ID_Flush_o           IF/ID clears to NOP
//   ID_EX_Bubble_o          ID/EX control fields forced to zero
//   pipe_freeze_o           ID/EX, EX/MEM, MEM/WB hold
//   stall_cnt_o             saturating count of cycles with PCWrite_o=0
//
// Optional feature: define HAZARD_STALL_COUNT_EN to build the stall counter;
// without it stall_cnt_o is tied to zero.

module hazard_stall_ctrl #(
    parameter int LU_CYCLES = 1,
    parameter int CNT_W     = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       IF_ID_RSaddr_i,
    input  logic [4:0]       IF_ID_RTaddr_i,
    input  logic [4:0]       ID_EX_RTaddr_i,
    input  logic             ID_EX_MemRead_i,
    input  logic             mem_stall_i,
    input  logic             branch_taken_i,
    output logic             PCWrite_o,
    output logic             IF_ID_Write_o,
    output logic             IF_ID_Flush_o,
    output logic             ID_EX_Bubble_o,
    output logic             pipe_freeze_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_LU_WAIT  = 2'd1,
        ST_MEM_WAIT = 2'd2
    } state_t;

    // The first load-use stall cycle happens in RUN; LU_WAIT covers the rest.
    localparam bit       LU_MULTI = (LU_CYCLES > 1);
    localparam logic [2:0] LU_INIT = 3'(LU_CYCLES - 1);

    state_t     state_q, state_d;
    state_t     saved_q, saved_d;   // state to resume once memory is ready
    state_t     eff_state;
    logic [2:0] lu_cnt_q, lu_cnt_d;
    logic       hit;

    // Register 0 is hard-wired, so a load targeting it never needs a stall.
    assign hit = ID_EX_MemRead_i && (ID_EX_RTaddr_i != 5'd0) &&
                 ((ID_EX_RTaddr_i == IF_ID_RSaddr_i) || (ID_EX_RTaddr_i == IF_ID_RTaddr_i));

    // When memory releases, this cycle behaves exactly as the saved state.
    assign eff_state = (state_q == ST_MEM_WAIT) ? saved_q : state_q;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_RUN;
            saved_q  <= ST_RUN;
            lu_cnt_q <= 3'd0;
        end else begin
            state_q  <= state_d;
            saved_q  <= saved_d;
            lu_cnt_q <= lu_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        saved_d  = saved_q;
        lu_cnt_d = lu_cnt_q;

        if (mem_stall_i) begin
            state_d = ST_MEM_WAIT;
            // A stall that continues across several cycles keeps the
            // originally saved state; lu_cnt is frozen untouched.
            if (state_q != ST_MEM_WAIT) begin
                saved_d = state_q;
            end
        end else begin
            case (eff_state)
                ST_LU_WAIT: begin
                    lu_cnt_d = lu_cnt_q - 3'd1;
                    if (lu_cnt_q <= 3'd1) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_LU_WAIT;
                    end
                end
                default: begin
                    state_d = ST_RUN;
                    if (hit && LU_MULTI) begin
                        state_d  = ST_LU_WAIT;
                        lu_cnt_d = LU_INIT;
                    end
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        PCWrite_o      = 1'b1;
        IF_ID_Write_o  = 1'b1;
        IF_ID_Flush_o  = 1'b0;
        ID_EX_Bubble_o = 1'b0;
        pipe_freeze_o  = 1'b0;

        if (rst_i) begin
            PCWrite_o      = 1'b0;
            IF_ID_Write_o  = 1'b0;
            ID_EX_Bubble_o = 1'b1;
        end else if (mem_stall_i) begin
            PCWrite_o     = 1'b0;
            IF_ID_Write_o = 1'b0;
            pipe_freeze_o = 1'b1;
        end else if ((eff_state == ST_LU_WAIT) || hit) begin
            // A branch seen here is dropped; it is re-resolved in ID
            // once the dependent instruction proceeds.
            PCWrite_o      = 1'b0;
            IF_ID_Write_o  = 1'b0;
            ID_EX_Bubble_o = 1'b1;
        end else if (branch_taken_i) begin
            IF_ID_Flush_o = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Stall cycle counter
    // ------------------------------------------------------------------
`ifdef HAZARD_STALL_COUNT_EN
    logic [CNT_W-1:0] stall_cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
        end else if (!PCWrite_o && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

    assign stall_cnt_o = rst_i ? '0 : stall_cnt_q;
`else
    assign stall_cnt_o = '0;
`endif

endmodule
